// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out bus bundle for conv_window_buffer.
// slave: the window buffer itself; master: the producer/consumer side.
interface conv_window_buffer_if #(
    parameter int DW    = 8,
    parameter int CRD_W = 8
);
    logic              pix_valid_i;
    logic              pix_ready_o;
    logic [DW-1:0]     pix_data_i;
    logic              win_valid_o;
    logic              win_ready_i;
    logic [9*DW-1:0]   win_data_o;
    logic [CRD_W-1:0]  win_row_o;
    logic [CRD_W-1:0]  win_col_o;
    logic              frame_done_o;

    modport slave (
        input  pix_valid_i, pix_data_i, win_ready_i,
        output pix_ready_o, win_valid_o, win_data_o, win_row_o, win_col_o, frame_done_o
    );

    modport master (
        output pix_valid_i, pix_data_i, win_ready_i,
        input  pix_ready_o, win_valid_o, win_data_o, win_row_o, win_col_o, frame_done_o
    );
endinterface

// File: rtl/conv_window_buffer.sv
// 3x3 sliding-window generator. Two line buffers hold the previous two image
// rows; a 3x3 shift register collects columns as pixels arrive in raster
// order. A window is emitted (registered, 1-cycle latency) for every pixel
// whose 3x3 neighbourhood lies fully inside the image.
module conv_window_buffer #(
    parameter int DW    = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CRD_W = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 clr_i,
    conv_window_buffer_if.slave  bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CRD_W-1:0] COL_LAST = CRD_W'(IMG_W - 1);
    localparam logic [CRD_W-1:0] ROW_LAST = CRD_W'(IMG_H - 1);
    localparam logic [CRD_W-1:0] ONE      = CRD_W'(1);
    localparam logic [CRD_W-1:0] TWO      = CRD_W'(2);

    // Line buffers: lb0 holds the row above the current one, lb1 two rows up.
    // Not reset: window emission is gated on row>=2, so stale data never escapes.
    logic [DW-1:0]    lb0_q [IMG_W];
    logic [DW-1:0]    lb1_q [IMG_W];

    logic [CRD_W-1:0] row_q, row_d;
    logic [CRD_W-1:0] col_q, col_d;
    logic             win_valid_q, win_valid_d;
    logic [9*DW-1:0]  win_data_q, win_data_d;
    logic [CRD_W-1:0] win_row_q, win_row_d;
    logic [CRD_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;

    logic             pix_ready;
    logic             accept;
    logic             emit;
    logic             col_wrap;
    logic             row_wrap;
    logic [AW-1:0]    lb_idx;
    logic [DW-1:0]    lb0_rd;
    logic [DW-1:0]    lb1_rd;

    // A pixel may enter whenever the output register is free or being drained.
    assign pix_ready = ~clr_i & (~win_valid_q | bus.win_ready_i);
    assign accept    = bus.pix_valid_i & pix_ready;
    assign emit      = accept & (row_q >= TWO) & (col_q >= TWO);
    assign col_wrap  = (col_q == COL_LAST);
    assign row_wrap  = (row_q == ROW_LAST);

    assign lb_idx = col_q[AW-1:0];
    assign lb0_rd = lb0_q[lb_idx];
    assign lb1_rd = lb1_q[lb_idx];

    // Next-state: advance counters, shift the window and load outputs on accept.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        win_data_d   = win_data_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = frame_done_q;

        if (accept) begin
            // Raster counters
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end

            // Shift columns left; the new right column is read from the
            // buffers before they are overwritten this cycle.
            for (int r = 0; r < 3; r++) begin
                win_data_d[(3*r)*DW   +: DW] = win_data_q[(3*r+1)*DW +: DW];
                win_data_d[(3*r+1)*DW +: DW] = win_data_q[(3*r+2)*DW +: DW];
            end
            win_data_d[2*DW +: DW] = lb1_rd;
            win_data_d[5*DW +: DW] = lb0_rd;
            win_data_d[8*DW +: DW] = bus.pix_data_i;

            win_valid_d  = emit;
            frame_done_d = emit & col_wrap & row_wrap;
            if (emit) begin
                win_row_d = row_q - ONE;
                win_col_d = col_q - ONE;
            end
        end else if (win_valid_q & bus.win_ready_i) begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State registers; reset and frame flush share the same effect.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || clr_i) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line-buffer update: push the column down one row and store the new pixel.
    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            lb1_q[lb_idx] <= lb0_rd;
            lb0_q[lb_idx] <= bus.pix_data_i;
        end
    end

    assign bus.pix_ready_o  = pix_ready;
    assign bus.win_valid_o  = win_valid_q;
    assign bus.win_data_o   = win_data_q;
    assign bus.win_row_o    = win_row_q;
    assign bus.win_col_o    = win_col_q;
    assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer on a 4x4 image.
module tb_conv_window_buffer;
    localparam int DW = 8, IW = 4, IH = 4, CW = 8;
    // First window of a frame with pixel = 4r+c: 0,1,2 / 4,5,6 / 8,9,10
    localparam logic [71:0] FIRST_WIN = 72'h0a_09_08_06_05_04_02_01_00;

    typedef struct {
        logic [71:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        done;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    bit   chk_first = 1'b0;
    int   rdy_mode = 0;
    win_t exp_q[$];

    conv_window_buffer_if #(.DW(DW), .CRD_W(CW)) bus ();

    conv_window_buffer #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .CRD_W(CW)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .clr_i    (clr),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] make_win(input int base, input int rr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*8 +: 8] = 8'(base + (rr-1+r)*IW + (cc-1+c));
        return w;
    endfunction

    // Random downstream readiness when enabled
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) bus.win_ready_i = 1'($urandom_range(0, 1));
    end

    // Monitor: pop and compare on every consumed window
    always @(negedge clk) begin
        if (rst_n && bus.win_valid_o && chk_first) begin
            chk("first_window_pixels", 72'(acc_cnt), 72'd11);
            chk_first = 1'b0;
        end
        if (rst_n && bus.win_valid_o && bus.win_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got row %0d col %0d expected none",
                         bus.win_row_o, bus.win_col_o);
            end else begin
                win_t e;
                e = exp_q.pop_front();
                chk("win_data", bus.win_data_o, e.data);
                chk("win_row", 72'(bus.win_row_o), 72'(e.row));
                chk("win_col", 72'(bus.win_col_o), 72'(e.col));
                chk("frame_done", 72'(bus.frame_done_o), 72'(e.done));
            end
        end
        if (rst_n && bus.pix_valid_i && bus.pix_ready_o) acc_cnt++;
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_pix(input logic [7:0] v, input int gap);
        int n;
        bus.pix_valid_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.pix_valid_i = 1'b1;
        bus.pix_data_i  = v;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.pix_ready_o) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL pix_accept_timeout: got ready 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int base, input int gap_max);
        for (int rr = 1; rr <= IH-2; rr++)
            for (int cc = 1; cc <= IW-2; cc++) begin
                win_t e;
                e.data = make_win(base, rr, cc);
                e.row  = 8'(rr);
                e.col  = 8'(cc);
                e.done = (rr == IH-2) && (cc == IW-2);
                exp_q.push_back(e);
            end
        for (int p = 0; p < IW*IH; p++)
            send_pix(8'(base + p), (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
        bus.pix_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin @(posedge clk); n++; end
        chk("drain_pending", 72'(exp_q.size()), 72'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pix_valid_i = 1'b1;
        bus.pix_data_i  = '0;
        bus.win_ready_i = 1'b1;

        // 1. reset with valid held high
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.pix_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_pix_ready", 72'(bus.pix_ready_o), 72'd1);
        chk("rst_win_valid", 72'(bus.win_valid_o), 72'd0);
        chk("rst_frame_done", 72'(bus.frame_done_o), 72'd0);
        chk("rst_win_data", bus.win_data_o, 72'd0);
        chk("rst_win_row", 72'(bus.win_row_o), 72'd0);
        chk("rst_win_col", 72'(bus.win_col_o), 72'd0);
        @(posedge clk); #1;

        // 2. continuous input, always ready
        acc_cnt = 0;
        chk_first = 1'b1;
        send_frame(0, 0);
        drain();
        chk("first_window_seen", 72'(chk_first), 72'd0);

        // 3. backpressure on the first window
        bus.win_ready_i = 1'b0;
        fork
            send_frame(0, 0);
            begin
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.win_valid_o && n < 100);
                chk("bp_window_arrived", 72'(bus.win_valid_o), 72'd1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_pix_ready", 72'(bus.pix_ready_o), 72'd0);
                    chk("bp_win_valid", 72'(bus.win_valid_o), 72'd1);
                    chk("bp_win_data", bus.win_data_o, FIRST_WIN);
                end
                @(posedge clk); #1;
                bus.win_ready_i = 1'b1;
            end
        join
        drain();

        // 4. random input gaps and random downstream ready
        rdy_mode = 1;
        send_frame(0, 2);
        drain();
        rdy_mode = 0;
        @(posedge clk); #2;
        bus.win_ready_i = 1'b1;
        @(posedge clk); #1;

        // 5. flush after a partial frame
        for (int p = 0; p < 6; p++) send_pix(8'(p + 100), 0);
        bus.pix_valid_i = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_pix_ready", 72'(bus.pix_ready_o), 72'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.pix_valid_i = 1'b0;
        @(negedge clk);
        chk("clr_win_valid", 72'(bus.win_valid_o), 72'd0);
        @(posedge clk); #1;
        send_frame(0, 0);
        drain();

        // 6. two frames back to back
        send_frame(0, 0);
        send_frame(16, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
